// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU data-bridge responder: FSM encoding,
// address map, timer control bit positions and the byte-merge helper.
package bridge_pkg;

    // FSM encoding (kept as plain constants for legacy tools)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RAM_RD = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Address map
    localparam logic [15:0] RAM_HI = 16'h0000;
    localparam logic [23:0] DEV_HI = 24'hFFFF00;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_TCOUNT = 8'h08;
    localparam logic [7:0] OFF_TCMP   = 8'h0C;
    localparam logic [7:0] OFF_TCTRL  = 8'h10;

    // TCTRL bit positions
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_PEND = 1;
    localparam int TCTRL_IEN  = 2;

    // Timer register select
    typedef enum logic [1:0] {
        TSEL_COUNT = 2'd0,
        TSEL_CMP   = 2'd1,
        TSEL_CTRL  = 2'd2
    } tsel_e;

    // Replace the bytes of old_v selected by be with the bytes of new_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bridge_timer.sv
// Free-running compare timer: count/cmp/ctrl registers, match-and-clear,
// sticky pending flag (write-1-to-clear) and a registered interrupt.
module bridge_timer
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  tsel_e       sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        ien_q, ien_d;
    logic        irq_q, irq_d;
    logic        match;
    logic        w1c;

    // Next-state: counting, CPU overrides, pending set beats W1C
    always_comb begin
        match   = en_q && (count_q == cmp_q);
        count_d = count_q;
        if (en_q) begin
            count_d = match ? 32'd0 : count_q + 32'd1;
        end
        if (wr_i && sel_i == TSEL_COUNT) begin
            count_d = wdata_i;
        end
        cmp_d = (wr_i && sel_i == TSEL_CMP) ? wdata_i : cmp_q;
        en_d  = en_q;
        ien_d = ien_q;
        w1c   = 1'b0;
        if (wr_i && sel_i == TSEL_CTRL) begin
            en_d  = wdata_i[TCTRL_EN];
            ien_d = wdata_i[TCTRL_IEN];
            w1c   = wdata_i[TCTRL_PEND];
        end
        pend_d = match | (pend_q & ~w1c);
        // irq shares the register stage with pending, so no extra delay
        irq_d  = pend_d & ien_d;
    end

    // Readback mux for the selected register
    always_comb begin
        case (sel_i)
            TSEL_COUNT: rdata_o = count_q;
            TSEL_CMP:   rdata_o = cmp_q;
            TSEL_CTRL:  rdata_o = {29'd0, ien_q, pend_q, en_q};
            default:    rdata_o = 32'd0;
        endcase
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            cmp_q   <= '0;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            ien_q   <= ien_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/bus_bridge_responder.sv
// Peripheral end of the CPU data bridge: one load/store at a time, routed
// to the data RAM or the LED/switch/timer registers, single-cycle response.
module bus_bridge_responder
    import bridge_pkg::*;
#(
    parameter int DMEM_AW = 12,
    parameter int LED_W   = 16,
    parameter int SW_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               req_ready,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         be,
    output logic               resp_valid,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [DMEM_AW-1:0] ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata,
    output logic [LED_W-1:0]   led,
    input  logic [SW_W-1:0]    sw,
    output logic               irq
);

    state_t             state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               resp_valid_q, resp_valid_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic               idle;
    logic               accept;
    logic               is_ram;
    logic               is_dev;
    logic               dev_hit;
    logic               is_tmr;
    logic [7:0]         dev_off;
    tsel_e              tmr_sel;
    logic               tmr_wr;
    logic [31:0]        tmr_rd;
    logic [31:0]        dev_old;
    logic [31:0]        merge_old;
    logic [31:0]        merged;
    logic               unused_addr_bits;

    assign idle     = (state_q == ST_IDLE);
    assign accept   = idle & req;
    assign is_ram   = (addr[31:16] == RAM_HI);
    assign is_dev   = (addr[31:8] == DEV_HI);
    assign dev_off  = {addr[7:2], 2'b00};
    assign is_tmr   = is_dev && (dev_off == OFF_TCOUNT || dev_off == OFF_TCMP ||
                                 dev_off == OFF_TCTRL);
    assign tmr_wr   = accept & we & is_tmr;

    // Byte offset and RAM-aliasing address bits carry no meaning here
    assign unused_addr_bits = ^{addr[1:0], addr[15:DMEM_AW+2]};

    // RAM port is driven straight from the accept cycle
    assign ram_en    = accept & is_ram;
    assign ram_we    = (accept & is_ram & we) ? be : 4'b0000;
    assign ram_addr  = addr[DMEM_AW+1:2];
    assign ram_wdata = wdata;

    // Timer register select from the device offset
    always_comb begin
        case (dev_off)
            OFF_TCMP:  tmr_sel = TSEL_CMP;
            OFF_TCTRL: tmr_sel = TSEL_CTRL;
            default:   tmr_sel = TSEL_COUNT;
        endcase
    end

    // Current device register value (read data and merge base)
    always_comb begin
        dev_hit = 1'b1;
        dev_old = 32'd0;
        case (dev_off)
            OFF_LED:    dev_old = 32'(led_q);
            OFF_SW:     dev_old = 32'(sw);
            OFF_TCOUNT: dev_old = tmr_rd;
            OFF_TCMP:   dev_old = tmr_rd;
            OFF_TCTRL:  dev_old = tmr_rd;
            default:    dev_hit = 1'b0;
        endcase
    end

    // Pending is W1C: a byte left unwritten must not echo it back as a clear
    assign merge_old = (dev_off == OFF_TCTRL) ? (dev_old & ~(32'd1 << TCTRL_PEND))
                                              : dev_old;
    assign merged    = byte_merge(merge_old, wdata, be);

    bridge_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (tmr_wr),
        .sel_i   (tmr_sel),
        .wdata_i (merged),
        .rdata_o (tmr_rd),
        .irq_o   (irq)
    );

    // FSM and response datapath next-state
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        led_d   = led_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (is_ram) begin
                        if (!we) begin
                            state_d = ST_RAM_RD;
                        end
                    end else if (is_dev && dev_hit) begin
                        if (we) begin
                            if (dev_off == OFF_LED) begin
                                led_d = merged[LED_W-1:0];
                            end
                        end else begin
                            rdata_d = dev_old;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RAM_RD: begin
                rdata_d = ram_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        resp_valid_d = (state_d == ST_RESP);
    end

    // Bridge state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            led_q        <= led_d;
        end
    end

    assign req_ready  = idle;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign led        = led_q;

endmodule

// File: tb/tb_bus_bridge_responder.sv
// Randomized scoreboard bench for bus_bridge_responder with a transaction-
// level reference model (memory map, LED register, closed-form timer).
module tb_bus_bridge_responder;

    localparam int DMEM_AW = 12;
    localparam int LED_W   = 16;
    localparam int SW_W    = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req = 1'b0;
    logic               req_ready;
    logic               we = 1'b0;
    logic [31:0]        addr = 32'd0;
    logic [31:0]        wdata = 32'd0;
    logic [3:0]         be = 4'd0;
    logic               resp_valid;
    logic [31:0]        rdata;
    logic               err;
    logic               ram_en;
    logic [3:0]         ram_we;
    logic [DMEM_AW-1:0] ram_addr;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    logic [LED_W-1:0]   led;
    logic [SW_W-1:0]    sw = '0;
    logic               irq;

    bus_bridge_responder #(.DMEM_AW(DMEM_AW), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(req_ready), .we(we),
        .addr(addr), .wdata(wdata), .be(be), .resp_valid(resp_valid),
        .rdata(rdata), .err(err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .led(led), .sw(sw), .irq(irq)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one cycle of read latency
    logic [31:0] ram_arr [0:(1<<DMEM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_arr[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= ram_arr[ram_addr];
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          edge_no;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ref_mem [int];
    int          ram_keys[$];
    logic [15:0] led_m = 16'd0;

    // Timer as a closed-form segment: since edge m_kb the count started at
    // m_c0 and (if enabled) advances modulo cmp+1; pending is m_pb or any
    // wrap that has happened since then.
    bit     m_en = 0, m_ien = 0, m_pb = 0;
    longint m_c0 = 0, m_cmp = 0;
    int     m_kb = 0;

    function automatic longint cnt_after(input int k);
        if (!m_en) return m_c0;
        return (m_c0 + longint'(k - m_kb)) % (m_cmp + 1);
    endfunction

    function automatic bit pend_after(input int k);
        return m_pb || (m_en && longint'(k - m_kb) >= (m_cmp - m_c0 + 1));
    endfunction

    function automatic bit match_at(input int j);
        return m_en && (j > m_kb) && (cnt_after(j - 1) == m_cmp);
    endfunction

    function automatic bit model_irq(input int k);
        return pend_after(k) && m_ien;
    endfunction

    task automatic tmr_write(input int e_edge, input int sel, input logic [31:0] v);
        longint nc = cnt_after(e_edge);
        bit     np = pend_after(e_edge);
        bit     mt = match_at(e_edge);
        bit     pp = pend_after(e_edge - 1);
        case (sel)
            0: begin m_c0 = longint'(v); m_pb = np; end
            1: begin m_c0 = nc; m_cmp = longint'(v); m_pb = np; end
            default: begin
                m_c0  = nc;
                m_pb  = mt || (pp && !v[1]);
                m_en  = v[0];
                m_ien = v[2];
            end
        endcase
        m_kb = e_edge;
    endtask

    task automatic model_reset();
        led_m = 16'd0;
        m_en = 0; m_ien = 0; m_pb = 0; m_c0 = 0; m_cmp = 0; m_kb = cyc;
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_resp: got resp_valid=1, expected none (edge %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_edge", cyc, mon_e.edge_no);
                    chk("rdata", rdata, mon_e.rdata);
                    chk("err", {31'd0, err}, {31'd0, mon_e.err});
                end
            end
            chk("led", 32'(led), 32'(led_m));
            chk("irq", {31'd0, irq}, {31'd0, model_irq(cyc)});
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit hold);
        exp_t        e;
        bit          is_ram, is_dev, do_led, do_tmr;
        int          tsel, idx;
        logic [7:0]  off;
        logic [31:0] tmp;
        logic [15:0] led_new;
        wait_ready();
        if (!req_ready) begin
            n_vec++; n_miss++;
            $display("FAIL ready_timeout: got req_ready=0, expected 1 (edge %0d)", cyc);
            return;
        end
        we = w; addr = a; wdata = d; be = b; req = 1'b1;
        e.edge_no = cyc + 1; e.rdata = 32'd0; e.err = 1'b0;
        is_ram = (a[31:16] == 16'h0000);
        is_dev = (a[31:8] == 24'hFFFF00);
        off = {a[7:2], 2'b00};
        do_led = 0; do_tmr = 0; tsel = 0; led_new = led_m;
        idx = int'(a[DMEM_AW+1:2]);
        if (is_ram) begin
            if (w) begin
                tmp = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
                if (b != 4'd0) begin
                    if (!ref_mem.exists(idx)) ram_keys.push_back(idx);
                    ref_mem[idx] = bmerge(tmp, d, b);
                end
            end else begin
                e.rdata   = ref_mem[idx];
                e.edge_no = cyc + 2;
            end
        end else if (is_dev && off == 8'h00) begin
            if (w) begin tmp = bmerge(32'(led_m), d, b); led_new = tmp[15:0]; do_led = 1; end
            else e.rdata = 32'(led_m);
        end else if (is_dev && off == 8'h04) begin
            if (!w) e.rdata = 32'(sw);
        end else if (is_dev && (off == 8'h08 || off == 8'h0C || off == 8'h10)) begin
            tsel = (off == 8'h08) ? 0 : (off == 8'h0C) ? 1 : 2;
            if (w) do_tmr = 1;
            else if (tsel == 0) e.rdata = 32'(cnt_after(cyc));
            else if (tsel == 1) e.rdata = 32'(m_cmp);
            else e.rdata = {29'd0, m_ien, pend_after(cyc), m_en};
        end else begin
            e.err = 1'b1;
        end
        exp_q.push_back(e);
        #1;
        chk("ram_en", {31'd0, ram_en}, {31'd0, is_ram});
        if (is_ram) begin
            chk("ram_addr", 32'(ram_addr), 32'(a[DMEM_AW+1:2]));
            chk("ram_we", {28'd0, ram_we}, {28'd0, (w ? b : 4'd0)});
            if (w) chk("ram_wdata", ram_wdata, d);
        end
        @(posedge clk); #1;
        if (do_led) led_m = led_new;
        if (do_tmr) tmr_write(cyc, tsel, d);
        if (!hold) req = 1'b0;
    endtask

    function automatic logic [31:0] unmapped_addr();
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 1) == 0) begin
            a = {24'hFFFF00, 8'(4 * $urandom_range(5, 63)) | 8'($urandom_range(0, 3))};
        end else if (a[31:16] == 16'h0000 || a[31:8] == 24'hFFFF00) begin
            a[31] = 1'b1;
        end
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, v;
        int          kind, g;
        longint      nxt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // RAM store then load of the same word
        issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        issue(0, 32'h0000_0010, 32'h0, 4'h0, 0);

        // LED byte-enable merge
        issue(1, 32'hFFFF_0000, 32'h0000_FFFF, 4'hF, 0);
        issue(1, 32'hFFFF_0000, 32'h0000_1200, 4'b0010, 0);
        issue(0, 32'hFFFF_0000, 32'h0, 4'h0, 0);

        // Unmapped load, write to read-only switches
        issue(0, 32'h8000_0000, 32'h0, 4'h0, 0);
        sw = 16'hA5C3;
        issue(1, 32'hFFFF_0004, 32'h1234_5678, 4'hF, 0);
        issue(0, 32'hFFFF_0004, 32'h0, 4'h0, 0);

        // Timer: cmp=3, enable with irq-enable, watch wrap and W1C
        issue(1, 32'hFFFF_000C, 32'd3, 4'hF, 0);
        issue(1, 32'hFFFF_0008, 32'd0, 4'hF, 0);
        issue(1, 32'hFFFF_0010, 32'h5, 4'hF, 0);
        repeat (4) issue(0, 32'hFFFF_0008, 32'h0, 4'h0, 0);
        issue(1, 32'hFFFF_0010, 32'h7, 4'hF, 0);
        issue(0, 32'hFFFF_0010, 32'h0, 4'h0, 0);
        // W1C landing on the same edge as a new match
        g = 0;
        while (!(req_ready && cnt_after(cyc) == 3) && g < 40) begin @(posedge clk); #1; g++; end
        issue(1, 32'hFFFF_0010, 32'h7, 4'hF, 0);
        issue(0, 32'hFFFF_0010, 32'h0, 4'h0, 0);
        issue(1, 32'hFFFF_0010, 32'h2, 4'hF, 0);

        // Back-to-back device reads with req held through RESP
        issue(0, 32'hFFFF_0000, 32'h0, 4'h0, 1);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        issue(0, 32'hFFFF_0004, 32'h0, 4'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            wait_ready();
            case (kind)
                0, 1, 2: begin
                    a = {16'h0000, 16'($urandom)};
                    v = $urandom;
                    if (!ref_mem.exists(int'(a[DMEM_AW+1:2]))) issue(1, a, v, 4'hF, 0);
                    else issue(1, a, v, 4'($urandom), 0);
                end
                3, 4: begin
                    if (ram_keys.size() == 0) issue(1, 32'h0000_0100, $urandom, 4'hF, 0);
                    else begin
                        a = {16'h0000, 2'($urandom),
                             12'(ram_keys[$urandom_range(0, ram_keys.size() - 1)]), 2'($urandom)};
                        issue(0, a, 32'h0, 4'h0, 0);
                    end
                end
                5: issue(1'($urandom), {24'hFFFF00, 6'd0, 2'($urandom)}, $urandom, 4'($urandom), 0);
                6: begin
                    sw = 16'($urandom);
                    issue(1'($urandom), 32'hFFFF_0004, $urandom, 4'hF, 0);
                end
                7: begin
                    case ($urandom_range(0, 4))
                        0: issue(0, 32'hFFFF_0008 + 32'(4 * $urandom_range(0, 2)), 32'h0, 4'h0, 0);
                        1: issue(1, 32'hFFFF_0008, 32'($urandom_range(0, int'(m_cmp))), 4'hF, 0);
                        2: begin
                            nxt = cnt_after(cyc + 1);
                            issue(1, 32'hFFFF_000C, 32'(nxt + longint'($urandom_range(0, 10))), 4'hF, 0);
                        end
                        3: issue(1, 32'hFFFF_0010, 32'($urandom_range(0, 7)), 4'hF, 0);
                        default: issue(1, 32'hFFFF_0010, {29'd0, m_ien, 1'b1, m_en}, 4'hF, 0);
                    endcase
                end
                8: issue(1'($urandom), unmapped_addr(), $urandom, 4'($urandom), 0);
                default: repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset in the RAM_RD cycle of a load
        issue(1, 32'hFFFF_0000, 32'h0000_BEEF, 4'hF, 0);
        issue(1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 0);
        issue(0, 32'h0000_0020, 32'h0, 4'h0, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        issue(0, 32'h0000_0020, 32'h0, 4'h0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
